// File: rtl/fft_mag_peak.sv
// Magnitude-squared and per-channel frame peak tracker for the FFT output stream.
// Two-stage pipeline: squares, then sum; peak captured on the output handshake.
module fft_mag_peak #(
  parameter int FFT_LEN            = 8192,
  parameter int FFT_CHANNELS       = 2,
  parameter int FFT_AXI_DATA_WIDTH = 32,
  parameter int FFT_INDEX_LEN      = 32,
  parameter int MAG_WIDTH          = FFT_AXI_DATA_WIDTH
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [FFT_CHANNELS*FFT_AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                                  s_axis_tvalid,
  input  logic                                  s_axis_tlast,
  output logic                                  s_axis_tready,
  output logic [FFT_CHANNELS*MAG_WIDTH-1:0]     m_axis_tdata,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic [FFT_INDEX_LEN-1:0]              m_index,
  output logic [FFT_CHANNELS*MAG_WIDTH-1:0]     peak_mag,
  output logic [FFT_CHANNELS*FFT_INDEX_LEN-1:0] peak_index,
  output logic                                  peak_valid,
  output logic                                  frame_err,
  output logic [15:0]                           frame_count
);

  localparam int CH = FFT_CHANNELS;
  localparam int DW = FFT_AXI_DATA_WIDTH;
  localparam int HW = DW / 2;
  localparam int MW = MAG_WIDTH;
  localparam int IW = FFT_INDEX_LEN;
  localparam logic [IW-1:0] LAST_BIN = IW'(FFT_LEN - 1);

  logic          en;
  logic          s_hs;
  logic          m_hs;
  logic [IW-1:0] bin;

  logic             v1;
  logic             last1;
  logic [IW-1:0]    idx1;
  logic [CH*DW-1:0] sq_re;
  logic [CH*DW-1:0] sq_im;
  logic [CH*DW-1:0] p_re;
  logic [CH*DW-1:0] p_im;

  logic [CH*MW-1:0] run_max;
  logic [CH*MW-1:0] nxt_max;
  logic [CH*IW-1:0] run_idx;
  logic [CH*IW-1:0] nxt_idx;

  function automatic logic [DW-1:0] sq(input logic [HW-1:0] x);
    logic signed [DW-1:0] w;
    w = {{(DW-HW){x[HW-1]}}, x};
    return $unsigned(w * w);
  endfunction

  assign en            = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = en;
  assign s_hs          = s_axis_tvalid && en;
  assign m_hs          = m_axis_tvalid && m_axis_tready;

  always_comb begin
    p_re = '0;
    p_im = '0;
    for (int c = 0; c < CH; c++) begin
      p_re[c*DW +: DW] = sq(s_axis_tdata[c*DW +: HW]);
      p_im[c*DW +: DW] = sq(s_axis_tdata[c*DW+HW +: HW]);
    end
  end

  // Counter wraps on a missing tlast; the error is reported at frame end.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bin <= '0;
    end else if (s_hs) begin
      if (s_axis_tlast || bin == LAST_BIN)
        bin <= '0;
      else
        bin <= bin + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      v1            <= 1'b0;
      last1         <= 1'b0;
      idx1          <= '0;
      sq_re         <= '0;
      sq_im         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_index       <= '0;
      m_axis_tdata  <= '0;
    end else if (en) begin
      v1 <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        sq_re <= p_re;
        sq_im <= p_im;
        last1 <= s_axis_tlast;
        idx1  <= bin;
      end
      m_axis_tvalid <= v1;
      if (v1) begin
        for (int c = 0; c < CH; c++)
          m_axis_tdata[c*MW +: MW] <= MW'(sq_re[c*DW +: DW])
                                    + MW'(sq_im[c*DW +: DW]);
        m_axis_tlast <= last1;
        m_index      <= idx1;
      end
    end
  end

  // Bin 0 reloads; strict compare keeps the lowest bin on ties.
  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    for (int c = 0; c < CH; c++) begin
      if (m_index == '0 ||
          m_axis_tdata[c*MW +: MW] > run_max[c*MW +: MW]) begin
        nxt_max[c*MW +: MW] = m_axis_tdata[c*MW +: MW];
        nxt_idx[c*IW +: IW] = m_index;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      run_max     <= '0;
      run_idx     <= '0;
      peak_mag    <= '0;
      peak_index  <= '0;
      peak_valid  <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      peak_valid <= m_hs && m_axis_tlast;
      if (m_hs) begin
        run_max <= nxt_max;
        run_idx <= nxt_idx;
        if (m_axis_tlast) begin
          peak_mag    <= nxt_max;
          peak_index  <= nxt_idx;
          frame_err   <= (m_index != LAST_BIN);
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/fft_mag_peak.md
Name: fft_mag_peak

Overview:
- Downstream of the FFT stage; consumes its complex multi-channel output stream.
- Computes per-channel magnitude-squared |X|^2 = re^2 + im^2 and forwards it as an AXI-Stream with matching bin index.
- Tracks the per-channel peak bin over each frame and presents peak magnitude and index when the frame ends.
- Feeds the range-bin detection and readout logic of the GPR chain.

Parameters:
- FFT_LEN, 8192, expected beats per frame (tlast position check).
- FFT_CHANNELS, 2, number of parallel complex channels per beat.
- FFT_AXI_DATA_WIDTH, 32, bits per channel per input beat: imag in upper half, real in lower half, both signed two's complement.
- FFT_INDEX_LEN, 32, width of bin index outputs.
- MAG_WIDTH, FFT_AXI_DATA_WIDTH, unsigned magnitude-squared width per channel; the full-range result always fits.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  FFT_CHANNELS*FFT_AXI_DATA_WIDTH  FFT output beat; channel c occupies slice c.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  last bin of frame.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  FFT_CHANNELS*MAG_WIDTH  magnitude-squared per channel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  last bin of frame, aligned with its data.
- m_axis_tready  in  1  downstream ready.
- m_index  out  FFT_INDEX_LEN  bin number of the current m_axis beat, 0-based.
- peak_mag  out  FFT_CHANNELS*MAG_WIDTH  per-channel frame maximum.
- peak_index  out  FFT_CHANNELS*FFT_INDEX_LEN  bin of that maximum.
- peak_valid  out  1  one-cycle pulse when peak_mag and peak_index update.
- frame_err  out  1  last frame's tlast was not at bin FFT_LEN-1.
- frame_count  out  16  completed frames, wraps at 65535 to 0.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. Reset clears all pipeline valids, counters and outputs to 0.
- Pipeline: 2 stages.
  - Stage 1 registers re^2 and im^2 as signed products.
  - Stage 2 registers their unsigned sum.
  - Data, tlast and index travel with valid.
  - Latency: 2 cycles from input handshake to m_axis_tvalid when unstalled.
- Flow control: stage advance enable = !stage2_valid | m_axis_tready. s_axis_tready = enable, combinational.
  - No beat may be dropped or duplicated under any tready pattern.
  - Full throughput of 1 beat/cycle when m_axis_tready is held high.
- Bin counter: increments on each input handshake and travels with the beat as m_index. It resets to 0 after the tlast handshake; the next beat is bin 0.
  - If the counter reaches FFT_LEN-1 without tlast, it wraps to 0 and the frame continues; the error is flagged at the eventual tlast.
- Peak tracking is evaluated on each output handshake (m_axis_tvalid & m_axis_tready), per channel independently.
  - Bin 0 loads the running max unconditionally.
  - Later bins replace it only if strictly greater, so ties keep the lowest bin.
- Frame end: on the output handshake with m_axis_tlast, the following happen on the same edge:
  - peak_mag/peak_index are loaded with the final max, including this beat.
  - peak_valid = 1 for exactly the next cycle, with no backpressure.
  - frame_err is set to (m_index != FFT_LEN-1); it holds until the next frame end.
  - frame_count increments.
- peak_mag, peak_index and frame_err hold their values between frame ends.
- Arithmetic: -32768^2 + -32768^2 = 2^31 must be exact. No saturation or rounding.
- Reset mid-frame: the partial frame is discarded. No peak_valid is generated; the next accepted beat is bin 0.

Test Plan:
- Single channel 0 frame of 8192 beats, re=im=0 except bin 100 with re=3, im=-4 → m_axis bin 100 shows 25; peak_index[0]=100, peak_mag[0]=25; one peak_valid pulse; frame_err=0; frame_count=1.
- Full-scale input re=im=-32768 at bin 5 of channel 1 → m_axis_tdata channel 1 = 0x80000000; peak_mag[1]=0x80000000, peak_index[1]=5.
- Equal magnitude 9 at bins 10 and 20 → peak_index=10 (tie keeps first).
- Random m_axis_tready (~50%) and random s_axis_tvalid gaps over 3 frames → output sequence matches the reference model beat-for-beat; tlast on bins 8191; 3 peak_valid pulses.
- tlast asserted at bin 4095 → m_axis_tlast at m_index 4095; frame_err=1; next frame starts at m_index 0; a correct following frame clears frame_err.
- areset pulsed at bin 3000 → all outputs 0 immediately; no peak_valid; next frame starts at m_index 0 and completes normally.
